// File: rtl/motion_sensor_array.sv
// N-channel car-park motion sensor: 2-flop sync, debounce, arrive/depart pulses, occupancy count.
// motion_out follows a stable input DEBOUNCE_CYCLES+2 edges later; no backpressure. Define STUCK_DETECT_EN for stuck timers.
module motion_sensor_array #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES    = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           car_detected,
  input  logic [NUM_CH-1:0]           ch_enable,
  output logic [NUM_CH-1:0]           motion_out,
  output logic [NUM_CH-1:0]           arrive_pulse,
  output logic [NUM_CH-1:0]           depart_pulse,
  output logic [$clog2(NUM_CH+1)-1:0] occupied_count,
  output logic                        any_motion,
  output logic [NUM_CH-1:0]           stuck_flag
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int OW = $clog2(NUM_CH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [CW-1:0]     deb_cnt [NUM_CH];
  logic [NUM_CH-1:0] flip;
  logic [OW-1:0]     pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= car_detected;
      sync2 <= sync1;
    end
  end

  // A channel flips on the edge where its counter has already seen DEBOUNCE_CYCLES-1 differing samples.
  always_comb begin
    flip = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      flip[i] = ch_enable[i] && (sync2[i] != motion_out[i]) && (deb_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      motion_out   <= '0;
      arrive_pulse <= '0;
      depart_pulse <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      arrive_pulse <= '0;
      depart_pulse <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ch_enable[i]) begin
          // Masking drops the level silently: no depart event for a disabled channel.
          motion_out[i] <= 1'b0;
          deb_cnt[i]    <= '0;
        end else if (sync2[i] == motion_out[i]) begin
          deb_cnt[i] <= '0;
        end else if (flip[i]) begin
          motion_out[i]   <= sync2[i];
          deb_cnt[i]      <= '0;
          arrive_pulse[i] <= sync2[i];
          depart_pulse[i] <= ~sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + OW'(motion_out[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupied_count <= '0;
      any_motion     <= 1'b0;
    end else begin
      occupied_count <= pop;
      any_motion     <= |motion_out;
    end
  end

`ifdef STUCK_DETECT_EN
  localparam int TW = $clog2(STUCK_CYCLES + 1);
  localparam logic [TW-1:0] TMR_MAX = TW'(STUCK_CYCLES);
  localparam logic [TW-1:0] TMR_PRE = TW'(STUCK_CYCLES - 1);

  logic [TW-1:0] stuck_tmr [NUM_CH];

  // Timer counts edges with motion_out high; the flag lands on the edge the timer reaches STUCK_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      stuck_flag <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        stuck_tmr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ch_enable[i] || !motion_out[i] || (flip[i] && !sync2[i])) begin
          stuck_tmr[i]  <= '0;
          stuck_flag[i] <= 1'b0;
        end else begin
          if (stuck_tmr[i] != TMR_MAX) begin
            stuck_tmr[i] <= stuck_tmr[i] + TW'(1);
          end
          if (stuck_tmr[i] >= TMR_PRE) begin
            stuck_flag[i] <= 1'b1;
          end
        end
      end
    end
  end
`else
  logic [31:0] unused_stuck_cycles;
  assign unused_stuck_cycles = 32'(STUCK_CYCLES);
  assign stuck_flag          = '0;
`endif

endmodule

// File: doc/motion_sensor_array.md
Name: motion_sensor_array

Overview:
- N-channel successor to the single-lane motion sensor. Serves every entry, exit and bay sensor in the car park from one block.
- Per channel: 2-flop synchroniser, then a programmable debounce filter, then a stable detection level and one-cycle arrive/depart event pulses.
- Provides a registered count of currently-detected channels and an any-motion flag for the parking controller FSM.

Parameters:
- NUM_CH, 4, number of sensor channels (1..32).
- DEBOUNCE_CYCLES, 4, consecutive synchronised samples that must differ from the stable level before it flips (>=1).
- STUCK_CYCLES, 1000, cycles a channel may stay detected before stuck_flag is raised. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- car_detected  in  NUM_CH  raw asynchronous sensor inputs, one bit per channel
- ch_enable  in  NUM_CH  per-channel enable; 0 = channel masked
- motion_out  out  NUM_CH  debounced stable detection level
- arrive_pulse  out  NUM_CH  one-cycle pulse on a 0->1 transition of motion_out
- depart_pulse  out  NUM_CH  one-cycle pulse on a 1->0 transition of motion_out
- occupied_count  out  $clog2(NUM_CH+1)  number of motion_out bits set
- any_motion  out  1  OR of motion_out, registered alongside occupied_count
- stuck_flag  out  NUM_CH  channel detected for too long; tied 0 without the optional feature

Behaviour:
- Clock and reset: single clock. Reset is synchronous, active-high, and sampled on the clk rising edge.
- Reset values: all outputs 0; synchroniser flops, debounce counters and stuck timers all 0.
- Reset mid-operation: everything clears on that edge, with no pulses generated.
- Synchroniser: sync1 <= car_detected; sync2 <= sync1.
- Debounce, per channel (counter width max(1, $clog2(DEBOUNCE_CYCLES))):
  - If ch_enable[i] = 0: motion_out[i] <= 0, counter <= 0, no pulses; stuck timer and flag clear. A channel disabled while high drops to 0 with NO depart_pulse.
  - Else if sync2[i] == motion_out[i]: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: motion_out[i] <= sync2[i]; counter <= 0; the matching arrive/depart pulse is asserted on the same edge.
  - Else: counter <= counter+1.
- Latency: if edge k is the first edge sampling a new stable raw level, motion_out changes at edge k+1+DEBOUNCE_CYCLES. Example: DEBOUNCE_CYCLES = 4 gives edge k+5.
- Glitch rejection: a raw pulse whose synchronised width is < DEBOUNCE_CYCLES never changes motion_out. Any sample equal to the stable level resets the counter.
- Pulses: arrive_pulse and depart_pulse are registered and high for exactly one cycle. They are never both high on the same channel.
- Counting: occupied_count and any_motion are registered from the current motion_out, one cycle behind it. Simultaneous transitions on several channels in one cycle are all reflected in the count on the next edge.
- Count range: occupied_count never exceeds NUM_CH, so there is no wrap.
- Enable rising: a channel re-enabled while its input is high re-qualifies through the full debounce window, then pulses arrive.

Optional Feature:
- Macro STUCK_DETECT_EN.
- Defined: each channel has a timer of width $clog2(STUCK_CYCLES+1).
  - Timer increments while motion_out[i] = 1 and saturates at STUCK_CYCLES.
  - stuck_flag[i] <= 1 when the timer reaches STUCK_CYCLES.
  - Timer and flag clear on the edge where motion_out[i] becomes 0, on disable, or on rst.
- Undefined: no timers are synthesised and stuck_flag is constant 0.

Test Plan:
- Reset: assert rst for 2 cycles with all inputs high -> every output 0. Release rst -> motion_out[0] = 1 exactly 1+DEBOUNCE_CYCLES edges after the first sampling edge, with a single arrive_pulse[0] on that same edge.
- Glitch: DEBOUNCE_CYCLES = 4, drive car_detected[1] high for 3 cycles then low -> motion_out[1] stays 0 and no pulses occur. A 4-cycle pulse -> motion_out[1] = 1 for 4 cycles, with one arrive_pulse then one depart_pulse.
- Multi-channel: raise channels 0, 2 and 3 on the same cycle -> three arrive pulses on the same edge, occupied_count = 3 and any_motion = 1 one cycle later. Drop channel 2 -> count = 2.
- Enable mask: channel 1 detected, then ch_enable[1] <= 0 -> motion_out[1] = 0 next edge, no depart_pulse, count decremented. Re-enable with input still high -> arrive after the full debounce window.
- Reset mid-debounce: rst pulsed while counter = 2 -> counter and outputs 0, no pulse. After release, qualification restarts from 0.
- STUCK_DETECT_EN defined, STUCK_CYCLES = 10: hold channel 0 high -> stuck_flag[0] = 1 ten cycles after motion_out[0] rises; release the input -> flag clears with the depart_pulse. Macro undefined: flag stays 0.
